// File: rtl/mux_seq_pkg.sv
// Shared definitions for mux_seq_bank: FSM state encoding, counter sizing
// and the flat element-index macro for data_in.
`ifndef MUX_SEQ_ELEM_LSB
`define MUX_SEQ_ELEM_LSB(i, j, depth, width) ((((i) * (depth)) + (j)) * (width))
`endif

package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned depth, input int unsigned lanes);
        return (depth + lanes > 1) ? int'($clog2(depth + lanes)) : 1;
    endfunction

endpackage

// File: rtl/mux_seq_bank_lane.sv
// mux_lane: one registered DEPTH:1 mux lane with its own row snapshot,
// producing a zero-padded element plus valid/last flags.
module mux_lane
    import mux_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned OFFSET = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic                   active,
    input  logic [CNT_W-1:0]       t,
    input  logic [DEPTH*WIDTH-1:0] row_in,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic                   lane_last
);

    logic [DEPTH*WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [31:0]            t_ext, k;
    logic                   in_range;

    // k wraps to a huge value when t < OFFSET, so one compare covers both bounds
    assign t_ext    = 32'(t);
    assign k        = t_ext - OFFSET;
    assign in_range = (k < DEPTH);

    always_comb begin
        snap_d  = capture ? row_in : snap_q;
        out_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (active && in_range) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (k == j) out_d = snap_q[j*WIDTH +: WIDTH];
            end
            valid_d = 1'b1;
            last_d  = (k == DEPTH - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign lane_last = last_q;

endmodule

// File: rtl/mux_seq_bank.sv
// mux_seq_bank: LANES-wide bank of registered DEPTH:1 muxes streaming a snapshotted
// operand matrix. Define MUX_SEQ_SKEW_EN for the triangular (systolic) skew.
module mux_seq_bank
    import mux_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         flush,
    input  logic [LANES*DEPTH*WIDTH-1:0] data_in,
    output logic [LANES*WIDTH-1:0]       out,
    output logic [LANES-1:0]             out_valid,
    output logic [LANES-1:0]             lane_last,
    output logic                         busy,
    output logic                         done
);

`ifdef MUX_SEQ_SKEW_EN
    localparam int unsigned SKEW = 1;
`else
    localparam int unsigned SKEW = 0;
`endif
    localparam int unsigned     CNT_W  = cnt_w(DEPTH, LANES);
    localparam int unsigned     T      = DEPTH + SKEW * (LANES - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             done_q, done_d;
    logic             capture, active;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = 1'b0;
        capture = 1'b0;
        active  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    t_d     = '0;
                    capture = 1'b1;
                end
            end
            RUN: begin
                active = 1'b1;
                if (t_q == T_LAST) state_d = DONE;
                else               t_d     = t_q + CNT_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b0;
            capture = 1'b0;
            active  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mux_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W),
            .OFFSET(i * SKEW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .capture  (capture),
            .active   (active),
            .t        (t_q),
            .row_in   (data_in[`MUX_SEQ_ELEM_LSB(i, 0, DEPTH, WIDTH) +: DEPTH*WIDTH]),
            .out      (out[i*WIDTH +: WIDTH]),
            .out_valid(out_valid[i]),
            .lane_last(lane_last[i])
        );
    end

endmodule

// File: tb/tb_mux_seq_bank.sv
// Self-checking bench for mux_seq_bank: directed passes plus random matrices
// against a cycle-indexed matrix-streaming model.
module tb_mux_seq_bank;

    localparam int W = 16;
    localparam int L = 4;
    localparam int D = 4;
`ifdef MUX_SEQ_SKEW_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    localparam int T = D + S * (L - 1);

    logic             clk = 1'b0;
    logic             rst_n, start, flush;
    logic [L*D*W-1:0] data_in;
    logic [L*W-1:0]   out;
    logic [L-1:0]     out_valid, lane_last;
    logic             busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mat  [L][D];
    logic [W-1:0] snap [L][D];

    mux_seq_bank #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .data_in  (data_in),
        .out      (out),
        .out_valid(out_valid),
        .lane_last(lane_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mat();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < D; j++)
                data_in[(i*D+j)*W +: W] = mat[i][j];
    endtask

    task automatic set_fixed();
        mat = '{'{16'h0200, 16'h0100, 16'h0200, 16'h0100},
                '{16'h0000, 16'h0100, 16'h0000, 16'h0100},
                '{16'h0100, 16'h0200, 16'h0000, 16'h0100},
                '{16'h0100, 16'h0100, 16'h0100, 16'h0000}};
    endtask

    task automatic set_random();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < D; j++)
                mat[i][j] = 16'($urandom);
    endtask

    // Drives start for the E0 edge; the model snapshots the same matrix.
    task automatic pass_start(input bit hold);
        drive_mat();
        start = 1'b1;
        snap  = mat;
        step();
        if (!hold) start = 1'b0;
    endtask

    // n = edges since the start edge; n < 0 means idle with no pass pending.
    task automatic check_cycle(input string name, input int n);
        logic [L*W-1:0] eo;
        logic [L-1:0]   ev, el;
        eo = '0;
        ev = '0;
        el = '0;
        if (n >= 1 && n <= T) begin
            for (int i = 0; i < L; i++) begin
                int k;
                k = n - 1 - i * S;
                if (k >= 0 && k < D) begin
                    eo[i*W +: W] = snap[i][k];
                    ev[i]        = 1'b1;
                    el[i]        = (k == D - 1);
                end
            end
        end
        chk($sformatf("%s n=%0d out", name, n), 64'(out), 64'(eo));
        chk($sformatf("%s n=%0d out_valid", name, n), 64'(out_valid), 64'(ev));
        chk($sformatf("%s n=%0d lane_last", name, n), 64'(lane_last), 64'(el));
        chk($sformatf("%s n=%0d busy", name, n), 64'(busy), 64'(n >= 0 && n <= T));
        chk($sformatf("%s n=%0d done", name, n), 64'(done), 64'(n == T + 1));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        data_in = '0;
        #12;
        check_cycle("reset", -1);
        rst_n = 1'b1;
        step();
        check_cycle("post_reset", -1);

        // fixed matrix, data_in corrupted right after the start edge
        set_fixed();
        pass_start(1'b0);
        data_in = '1;
        check_cycle("fixed", 0);
        for (int n = 1; n <= T + 2; n++) begin
            step();
            check_cycle("fixed", n);
        end

        // start pulses during RUN and DONE are ignored
        set_random();
        pass_start(1'b0);
        check_cycle("ign", 0);
        for (int n = 1; n <= T + 3; n++) begin
            step();
            check_cycle("ign", n);
            if (n == 2)     start = 1'b1;
            if (n == 3)     start = 1'b0;
            if (n == T)     start = 1'b1;
            if (n == T + 1) start = 1'b0;
        end

        // back-to-back passes with start held high
        set_random();
        pass_start(1'b1);
        check_cycle("b2b_a", 0);
        for (int n = 1; n <= T + 1; n++) begin
            step();
            check_cycle("b2b_a", n);
            if (n == T) begin
                set_random();
                drive_mat();
            end
        end
        snap = mat;
        step();
        check_cycle("b2b_b", 0);
        start = 1'b0;
        for (int n = 1; n <= T + 2; n++) begin
            step();
            check_cycle("b2b_b", n);
        end

        // random matrices
        for (int r = 0; r < 3; r++) begin
            set_random();
            pass_start(1'b0);
            check_cycle("rand", 0);
            for (int n = 1; n <= T + 1; n++) begin
                step();
                check_cycle("rand", n);
            end
            step();
        end

        // flush on the third RUN cycle
        set_random();
        pass_start(1'b0);
        for (int n = 1; n <= 2; n++) begin
            step();
            check_cycle("pre_flush", n);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int n = 0; n < T + 2; n++) begin
            check_cycle("flush", -1);
            step();
        end

        // simultaneous start and flush in IDLE
        drive_mat();
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check_cycle("start_flush", -1);
        step();
        check_cycle("start_flush", -1);

        // asynchronous reset mid-RUN, then a fresh fixed pass
        set_random();
        pass_start(1'b0);
        for (int n = 1; n <= 2; n++) begin
            step();
            check_cycle("pre_rst", n);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_cycle("async_rst", -1);
        #2;
        rst_n = 1'b1;
        step();
        check_cycle("after_rst", -1);
        set_fixed();
        pass_start(1'b0);
        check_cycle("fresh", 0);
        for (int n = 1; n <= T + 2; n++) begin
            step();
            check_cycle("fresh", n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
